// File: rtl/ppm_symbol_serializer_if.sv
// -----------------------------------------------------------------------------
// ppm_symbol_serializer_if
//   Bundles the word-input handshake and the symbol-output bus of the PPM
//   symbol serializer.
//
//   Word side   : in_data, in_valid, in_ready, flush
//   Symbol side : sym_out, sym_valid, sym_start, word_done, busy
//
//   master : the upstream/downstream environment (drives words, observes symbols)
//   slave  : the serializer itself
// -----------------------------------------------------------------------------
interface ppm_symbol_serializer_if #(
  parameter int DATA_W = 8,
  parameter int SYM_W  = 2
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              flush;
  logic [SYM_W-1:0]  sym_out;
  logic              sym_valid;
  logic              sym_start;
  logic              word_done;
  logic              busy;

  modport master (
    output in_data, in_valid, flush,
    input  in_ready, sym_out, sym_valid, sym_start, word_done, busy
  );

  modport slave (
    input  in_data, in_valid, flush,
    output in_ready, sym_out, sym_valid, sym_start, word_done, busy
  );
endinterface

// File: rtl/ppm_symbol_serializer.sv
// -----------------------------------------------------------------------------
// ppm_symbol_serializer
//   Splits DATA_W-bit words into DATA_W/SYM_W symbols of SYM_W bits, each held
//   for HOLD_CYC clocks, for the PPM slot modulator. A one-word holding buffer
//   lets consecutive words run without a gap. word_done pulses EARLY clocks
//   before the last symbol of a word ends so the memory reader can prefetch.
//
// Ports
//   clk            system clock
//   rst_n          synchronous active-low reset
//   bus (slave)    in_data/in_valid/in_ready : word handshake
//                  flush                     : synchronous abort of word + buffer
//                  sym_out/sym_valid         : current symbol and its qualifier
//                  sym_start                 : first clock of each symbol
//                  word_done                 : early end-of-word pulse
//                  busy                      : sending or buffer occupied
// -----------------------------------------------------------------------------
module ppm_symbol_serializer #(
  parameter int DATA_W    = 8,
  parameter int SYM_W     = 2,
  parameter int HOLD_CYC  = 128,
  parameter int EARLY     = 2,
  parameter int MSB_FIRST = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  ppm_symbol_serializer_if.slave  bus
);

  localparam int NSYM = DATA_W / SYM_W;
  localparam int HW   = $clog2(HOLD_CYC);
  localparam int IW   = (NSYM > 1) ? $clog2(NSYM) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
  localparam logic [HW-1:0] HOLD_DONE = HW'(HOLD_CYC - 1 - EARLY);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NSYM - 1);

  // Reject parameter sets the datapath cannot represent.
  if (SYM_W < 1 || DATA_W < SYM_W || (DATA_W % SYM_W) != 0) begin : g_bad_width
    $error("ppm_symbol_serializer: DATA_W must be a non-zero multiple of SYM_W");
  end
  if (HOLD_CYC < 2) begin : g_bad_hold
    $error("ppm_symbol_serializer: HOLD_CYC must be >= 2");
  end
  if (EARLY < 0 || EARLY > HOLD_CYC - 1) begin : g_bad_early
    $error("ppm_symbol_serializer: EARLY must be in 0..HOLD_CYC-1");
  end
  if (MSB_FIRST != 0 && MSB_FIRST != 1) begin : g_bad_order
    $error("ppm_symbol_serializer: MSB_FIRST must be 0 or 1");
  end

  // Symbol visible at the output end of the shift register.
  function automatic logic [SYM_W-1:0] f_slice(input logic [DATA_W-1:0] w);
    if (MSB_FIRST != 0) begin
      return w[DATA_W-1 -: SYM_W];
    end else begin
      return w[SYM_W-1:0];
    end
  endfunction

  // Advance the shift register by one symbol towards the output end.
  function automatic logic [DATA_W-1:0] f_shift(input logic [DATA_W-1:0] w);
    if (MSB_FIRST != 0) begin
      return w << SYM_W;
    end else begin
      return w >> SYM_W;
    end
  endfunction

  logic [0:0]        r_state,    w_state_nxt;
  logic [DATA_W-1:0] r_shift,    w_shift_nxt;
  logic [DATA_W-1:0] r_buf,      w_buf_nxt;
  logic              r_buf_full, w_buf_full_nxt;
  logic [HW-1:0]     r_hold,     w_hold_nxt;
  logic [IW-1:0]     r_idx,      w_idx_nxt;

  logic [SYM_W-1:0]  r_sym_out;
  logic              r_sym_valid;
  logic              r_sym_start;
  logic              r_word_done;
  logic              r_busy;

  logic w_in_ready;
  logic w_accept;
  logic w_sym_end;
  logic w_word_end;
  logic w_buf_wr;
  logic w_live;

  // in_ready is combinational so it drops in the same clock rst_n is asserted.
  assign w_in_ready = rst_n & ~r_buf_full;
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_sym_end  = (r_hold == HOLD_LAST);
  assign w_word_end = (r_state == S_SEND) & w_sym_end & (r_idx == IDX_LAST);
  // A word accepted at end-of-word goes straight to the shift register, not the buffer.
  assign w_buf_wr   = (r_state == S_SEND) & w_accept & ~w_word_end;
  assign w_buf_nxt  = w_buf_wr ? bus.in_data : r_buf;

  // Next-state logic for FSM, shift register, hold/symbol counters and buffer flag.
  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_hold_nxt     = r_hold;
    w_idx_nxt      = r_idx;
    w_buf_full_nxt = r_buf_full | w_buf_wr;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_SEND;
          w_shift_nxt = bus.in_data;
          w_hold_nxt  = '0;
          w_idx_nxt   = '0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SEND: begin
        if (!w_sym_end) begin
          w_hold_nxt = r_hold + HW'(1);
        end else if (r_idx != IDX_LAST) begin
          w_hold_nxt  = '0;
          w_idx_nxt   = r_idx + IW'(1);
          w_shift_nxt = f_shift(r_shift);
        end else if (r_buf_full) begin
          w_hold_nxt     = '0;
          w_idx_nxt      = '0;
          w_shift_nxt    = r_buf;
          w_buf_full_nxt = 1'b0;
        end else if (w_accept) begin
          w_hold_nxt  = '0;
          w_idx_nxt   = '0;
          w_shift_nxt = bus.in_data;
        end else begin
          w_state_nxt = S_IDLE;
          w_hold_nxt  = '0;
          w_idx_nxt   = '0;
          w_shift_nxt = '0;
        end
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_shift_nxt    = '0;
        w_hold_nxt     = '0;
        w_idx_nxt      = '0;
        w_buf_full_nxt = 1'b0;
      end
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state.
  assign w_live = (w_state_nxt == S_SEND);

  // State, datapath and output registers; reset outranks flush, flush outranks accept.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.flush) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_buf       <= '0;
      r_buf_full  <= 1'b0;
      r_hold      <= '0;
      r_idx       <= '0;
      r_sym_out   <= '0;
      r_sym_valid <= 1'b0;
      r_sym_start <= 1'b0;
      r_word_done <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_buf       <= w_buf_nxt;
      r_buf_full  <= w_buf_full_nxt;
      r_hold      <= w_hold_nxt;
      r_idx       <= w_idx_nxt;
      r_sym_out   <= w_live ? f_slice(w_shift_nxt) : '0;
      r_sym_valid <= w_live;
      r_sym_start <= w_live & (w_hold_nxt == '0);
      r_word_done <= w_live & (w_idx_nxt == IDX_LAST) & (w_hold_nxt == HOLD_DONE);
      r_busy      <= w_live | w_buf_full_nxt;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.sym_out   = r_sym_out;
  assign bus.sym_valid = r_sym_valid;
  assign bus.sym_start = r_sym_start;
  assign bus.word_done = r_word_done;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_ppm_symbol_serializer.sv
// -----------------------------------------------------------------------------
// tb_ppm_symbol_serializer
//   Self-checking bench for ppm_symbol_serializer. Three instances share clk
//   and rst_n: LSB-first HOLD_CYC=4, MSB-first HOLD_CYC=4, and default
//   parameters (HOLD_CYC=128). One instance is selected at a time; the others
//   see idle inputs. A reference model tracks each word as a position within
//   its NSYM*HOLD_CYC-clock lifetime plus a one-entry pending slot, and derives
//   every expected output from that position with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_ppm_symbol_serializer;

  logic       clk = 1'b0;
  logic       tb_rstn = 1'b0;
  logic       tb_valid = 1'b0;
  logic       tb_flush = 1'b0;
  logic [7:0] tb_data = 8'h00;
  int         sel = 0;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int         m_hold = 4;
  int         m_len = 16;
  bit         m_msb = 1'b0;
  int         m_pos = -1;     // clock index inside the current word, -1 = idle
  logic [7:0] m_cur = 8'h00;
  logic [7:0] m_buf = 8'h00;
  bit         m_bufv = 1'b0;

  always #5 clk = ~clk;

  ppm_symbol_serializer_if #(.DATA_W(8), .SYM_W(2)) if0 ();
  ppm_symbol_serializer_if #(.DATA_W(8), .SYM_W(2)) if1 ();
  ppm_symbol_serializer_if #(.DATA_W(8), .SYM_W(2)) if2 ();

  assign if0.in_data  = tb_data;
  assign if0.in_valid = tb_valid && (sel == 0);
  assign if0.flush    = tb_flush && (sel == 0);
  assign if1.in_data  = tb_data;
  assign if1.in_valid = tb_valid && (sel == 1);
  assign if1.flush    = tb_flush && (sel == 1);
  assign if2.in_data  = tb_data;
  assign if2.in_valid = tb_valid && (sel == 2);
  assign if2.flush    = tb_flush && (sel == 2);

  ppm_symbol_serializer #(.DATA_W(8), .SYM_W(2), .HOLD_CYC(4), .EARLY(2), .MSB_FIRST(0))
    u_lsb (.clk(clk), .rst_n(tb_rstn), .bus(if0.slave));
  ppm_symbol_serializer #(.DATA_W(8), .SYM_W(2), .HOLD_CYC(4), .EARLY(2), .MSB_FIRST(1))
    u_msb (.clk(clk), .rst_n(tb_rstn), .bus(if1.slave));
  ppm_symbol_serializer u_def (.clk(clk), .rst_n(tb_rstn), .bus(if2.slave));

  // obs = {in_ready, busy, word_done, sym_start, sym_valid, sym_out[1:0]}
  logic [6:0] obs;
  always_comb begin
    case (sel)
      1:       obs = {if1.in_ready, if1.busy, if1.word_done, if1.sym_start, if1.sym_valid, if1.sym_out};
      2:       obs = {if2.in_ready, if2.busy, if2.word_done, if2.sym_start, if2.sym_valid, if2.sym_out};
      default: obs = {if0.in_ready, if0.busy, if0.word_done, if0.sym_start, if0.sym_valid, if0.sym_out};
    endcase
  end

  function automatic logic [6:0] exp_vec();
    int k;
    logic [1:0] s;
    if (m_pos < 0) return {tb_rstn && !m_bufv, m_bufv, 5'b00000};
    k = m_pos / m_hold;
    s = m_msb ? 2'(m_cur >> (8 - 2 * (k + 1))) : 2'(m_cur >> (2 * k));
    return {tb_rstn && !m_bufv, 1'b1, (m_pos == m_len - 1 - 2), (m_pos % m_hold == 0), 1'b1, s};
  endfunction

  task automatic model_step(input logic v, input logic [7:0] d, input logic f, input logic r);
    bit acc;
    acc = v && r && !m_bufv;
    if (!r || f) begin
      m_pos = -1;
      m_bufv = 1'b0;
    end else if (m_pos < 0) begin
      if (acc) begin m_cur = d; m_pos = 0; end
    end else if (m_pos == m_len - 1) begin
      if (m_bufv) begin m_cur = m_buf; m_bufv = 1'b0; m_pos = 0; end
      else if (acc) begin m_cur = d; m_pos = 0; end
      else m_pos = -1;
    end else begin
      m_pos++;
      if (acc) begin m_buf = d; m_bufv = 1'b1; end
    end
  endtask

  // Drive inputs at a negedge, let one posedge act, return at the next negedge.
  task automatic tick(input logic v, input logic [7:0] d, input logic f, input logic r);
    tb_valid = v; tb_data = d; tb_flush = f; tb_rstn = r;
    @(posedge clk);
    model_step(v, d, f, r);
    @(negedge clk);
  endtask

  task automatic set_sel(input int s);
    sel    = s;
    m_hold = (s == 2) ? 128 : 4;
    m_msb  = (s == 1);
    m_len  = 4 * m_hold;
  endtask

  task automatic go_idle(input int s);
    set_sel(s);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    set_sel(0);
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 8'hA5, 1'b0, 1'b0);
      checks++;
      if (obs !== 7'b0000000) begin
        errors++;
        $display("FAIL reset_outputs got=%b exp=%b", obs, 7'b0000000);
      end
    end
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (obs !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_release got=%b exp=%b", obs, 7'b1000000);
    end
  endtask

  // Single word 0xB4; seq holds the four expected symbols, first at [1:0].
  task automatic test_single(input int s, input logic [7:0] seq);
    logic [4:0] ex;
    go_idle(s);
    for (int n = 1; n <= 18; n++) begin
      tick(n == 1, 8'hB4, 1'b0, 1'b1);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL single_model sel=%0d n=%0d got=%b exp=%b", s, n, obs, exp_vec());
      end
      ex = (n <= 16) ? {n == 14, (n - 1) % 4 == 0, 1'b1, seq[2 * ((n - 1) / 4) +: 2]} : 5'b00000;
      checks++;
      if (obs[4:0] !== ex) begin
        errors++;
        $display("FAIL single_timing sel=%0d n=%0d got=%b exp=%b", s, n, obs[4:0], ex);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] seq;
    logic [5:0]  ex;
    seq = 16'h1EB4;   // symbols 0,1,3,2,2,3,1,0 from bit 0 upwards
    go_idle(0);
    for (int n = 1; n <= 34; n++) begin
      if (n == 1) tick(1'b1, 8'hB4, 1'b0, 1'b1);
      else if (n <= 17) tick(1'b1, 8'h1E, 1'b0, 1'b1);
      else tick(1'b0, 8'h00, 1'b0, 1'b1);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL b2b_model n=%0d got=%b exp=%b", n, obs, exp_vec());
      end
      ex = {!(n >= 2 && n <= 16),
            (n <= 32) ? {n == 14 || n == 30, (n - 1) % 4 == 0, 1'b1, seq[2 * ((n - 1) / 4) +: 2]} : 5'b00000};
      checks++;
      if ({obs[6], obs[4:0]} !== ex) begin
        errors++;
        $display("FAIL b2b_timing n=%0d got=%b exp=%b", n, {obs[6], obs[4:0]}, ex);
      end
    end
  endtask

  task automatic test_reset_mid_word();
    go_idle(0);
    for (int n = 1; n <= 30; n++) begin
      if (n == 1) tick(1'b1, 8'hB4, 1'b0, 1'b1);
      else if (n == 2) tick(1'b1, 8'h5A, 1'b0, 1'b1);
      else tick(1'b0, 8'h00, 1'b0, n != 11);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL rstmid_model n=%0d got=%b exp=%b", n, obs, exp_vec());
      end
      if (n >= 11) begin
        checks++;
        if (obs !== {n >= 12, 6'b000000}) begin
          errors++;
          $display("FAIL rstmid_quiet n=%0d got=%b exp=%b", n, obs, {n >= 12, 6'b000000});
        end
      end
    end
  endtask

  task automatic test_flush();
    go_idle(0);
    for (int n = 1; n <= 26; n++) begin
      if (n == 1) tick(1'b1, 8'hB4, 1'b0, 1'b1);
      else if (n == 2) tick(1'b1, 8'h5A, 1'b0, 1'b1);
      else if (n == 7) tick(1'b1, 8'hC3, 1'b1, 1'b1);
      else tick(1'b0, 8'h00, 1'b0, 1'b1);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL flush_model n=%0d got=%b exp=%b", n, obs, exp_vec());
      end
      if (n >= 7) begin
        checks++;
        if (obs !== 7'b1000000) begin
          errors++;
          $display("FAIL flush_quiet n=%0d got=%b exp=%b", n, obs, 7'b1000000);
        end
      end
    end
  endtask

  task automatic test_default_params();
    logic [4:0] ex;
    go_idle(2);
    for (int n = 1; n <= 515; n++) begin
      tick(n == 1, 8'hFF, 1'b0, 1'b1);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL default_model n=%0d got=%b exp=%b", n, obs, exp_vec());
      end
      ex = (n <= 512) ? {n == 510, (n - 1) % 128 == 0, 1'b1, 2'b11} : 5'b00000;
      checks++;
      if (obs[4:0] !== ex) begin
        errors++;
        $display("FAIL default_timing n=%0d got=%b exp=%b", n, obs[4:0], ex);
      end
    end
  endtask

  task automatic test_random(input int s, input int cycles);
    logic v, f, r;
    logic [7:0] d;
    go_idle(s);
    for (int n = 0; n < cycles; n++) begin
      v = ($urandom_range(0, 99) < 60);
      f = ($urandom_range(0, 99) < 2);
      r = ($urandom_range(0, 199) != 0);
      d = 8'($urandom);
      tick(v, d, f, r);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL random sel=%0d n=%0d got=%b exp=%b", s, n, obs, exp_vec());
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single(0, 8'hB4);   // LSB-first: 0,1,3,2
    test_single(1, 8'h1E);   // MSB-first: 2,3,1,0
    test_back_to_back();
    test_reset_mid_word();
    test_flush();
    test_default_params();
    test_random(0, 800);
    test_random(1, 800);
    test_random(2, 600);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "simulation time limit reached");
  end

endmodule
